// File: rtl/irq_gateway_pkg.sv
// Shared constants for the interrupt gateway: register word offsets and default
// filter width.
package irq_gateway_pkg;

    localparam int FILT_W_DEF = 4;

    // Word index = byte address [11:2]
    localparam logic [9:0] REG_STATUS     = 10'h000;
    localparam logic [9:0] REG_FILTER_LEN = 10'h001;
    localparam logic [9:0] REG_LATCH_EN   = 10'h002;
    localparam logic [9:0] REG_LATCH_CLR  = 10'h003;
    localparam logic [9:0] REG_RAW        = 10'h004;

endpackage

// File: rtl/irq_gw_chan.sv
// One interrupt source: 2-flop synchronizer, glitch filter with programmable
// length, and a rising-edge latch selectable against the filtered level.
module irq_gw_chan #(
    parameter int FILT_W = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              raw,
    input  logic [FILT_W-1:0] filter_len,
    input  logic              latch_en,
    input  logic              latch_clr,
    output logic              sync,
    output logic              irq
);

    logic              meta;
    logic              sync_q;
    logic              filt;
    logic              filt_d;
    logic              latch;
    logic [FILT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
            latch  <= 1'b0;
            cnt    <= '0;
        end else begin
            meta   <= raw;
            sync_q <= meta;
            filt_d <= filt;

            // >= rather than == so that shrinking filter_len mid-count still flips
            if (sync_q == filt) begin
                cnt <= '0;
            end else if (cnt >= filter_len) begin
                filt <= sync_q;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A new rising edge beats a simultaneous clear so no edge is lost
            if (filt && !filt_d) begin
                latch <= 1'b1;
            end else if (latch_clr) begin
                latch <= 1'b0;
            end
        end
    end

    assign sync = sync_q;
    assign irq  = latch_en ? latch : filt;

endmodule

// File: rtl/irq_gateway.sv
// Interrupt conditioning in front of the PLIC: per-source sync/filter/latch
// channels plus a small MMIO register file with one-cycle read latency.
module irq_gateway
    import irq_gateway_pkg::*;
#(
    parameter int NSRC   = 32,
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [NSRC-1:0] irq_raw_i,
    input  logic            reg_en_i,
    input  logic [31:0]     reg_addr_i,
    input  logic [31:0]     reg_wdata_i,
    input  logic            reg_we_i,
    output logic [31:0]     reg_rdata_o,
    output logic            reg_ready_o,
    output logic [NSRC-1:0] irqs_o
);

    logic [FILT_W-1:0] filter_len;
    logic [NSRC-1:0]   latch_en;
    logic [NSRC-1:0]   latch_clr;
    logic [NSRC-1:0]   sync;
    logic [9:0]        addr_q;
    logic [9:0]        idx;
    logic              wr;
    logic              unused_addr;

    assign idx         = reg_addr_i[11:2];
    assign wr          = reg_en_i & reg_we_i;
    assign unused_addr = ^{reg_addr_i[31:12], reg_addr_i[1:0]};
    assign reg_ready_o = 1'b1;

    // LATCH_CLR is a write pulse; the channel clears on the same edge that
    // samples the write, so the effect is visible the following cycle.
    assign latch_clr = (wr && idx == REG_LATCH_CLR) ? reg_wdata_i[NSRC-1:0] : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            filter_len <= '0;
            latch_en   <= '0;
            addr_q     <= '0;
        end else begin
            addr_q <= idx;
            if (wr) begin
                case (idx)
                    REG_FILTER_LEN: filter_len <= reg_wdata_i[FILT_W-1:0];
                    REG_LATCH_EN:   latch_en   <= reg_wdata_i[NSRC-1:0];
                    default:        ;
                endcase
            end
        end
    end

    // Decoded from the address captured every clock, matching PLIC read timing
    always_comb begin
        reg_rdata_o = '0;
        case (addr_q)
            REG_STATUS:     reg_rdata_o[NSRC-1:0]   = irqs_o;
            REG_FILTER_LEN: reg_rdata_o[FILT_W-1:0] = filter_len;
            REG_LATCH_EN:   reg_rdata_o[NSRC-1:0]   = latch_en;
            REG_RAW:        reg_rdata_o[NSRC-1:0]   = sync;
            default:        reg_rdata_o             = '0;
        endcase
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_chan
        irq_gw_chan #(
            .FILT_W (FILT_W)
        ) u_chan (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .raw        (irq_raw_i[i]),
            .filter_len (filter_len),
            .latch_en   (latch_en[i]),
            .latch_clr  (latch_clr[i]),
            .sync       (sync[i]),
            .irq        (irqs_o[i])
        );
    end

endmodule

// File: tb/tb_irq_gateway.sv
// Directed bench for irq_gateway: register-access vector table followed by
// hand-timed filter, latch and reset sequences.
module tb_irq_gateway;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [31:0] irq_raw_i;
    logic        reg_en_i;
    logic [31:0] reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic        reg_we_i;
    logic [31:0] reg_rdata_o;
    logic        reg_ready_o;
    logic [31:0] irqs_o;

    int n_checks = 0;
    int n_fail   = 0;

    irq_gateway #(.NSRC(32), .FILT_W(4)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .irq_raw_i   (irq_raw_i),
        .reg_en_i    (reg_en_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_we_i    (reg_we_i),
        .reg_rdata_o (reg_rdata_o),
        .reg_ready_o (reg_ready_o),
        .irqs_o      (irqs_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] raw;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rstn_i      = 1'b0;
        irq_raw_i   = '0;
        reg_en_i    = 1'b0;
        reg_we_i    = 1'b0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
    endtask

    task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
        reg_en_i    = 1'b1;
        reg_we_i    = 1'b1;
        reg_addr_i  = addr;
        reg_wdata_i = data;
        step(1);
        reg_en_i    = 1'b0;
        reg_we_i    = 1'b0;
    endtask

    task automatic reg_read(input logic [31:0] addr, output logic [31:0] data);
        reg_en_i   = 1'b1;
        reg_we_i   = 1'b0;
        reg_addr_i = addr;
        step(1);
        data       = reg_rdata_o;
        reg_en_i   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        seen;
        logic [15:0] got, exp;

        //            raw           we    addr          wdata         chk   exp
        vt[0]  = '{32'h0,        1'b0, 32'h0000, 32'h0,        1'b1, 32'h0};
        vt[1]  = '{32'h0,        1'b0, 32'h0004, 32'h0,        1'b1, 32'h0};
        vt[2]  = '{32'h0,        1'b0, 32'h0008, 32'h0,        1'b1, 32'h0};
        vt[3]  = '{32'h0,        1'b0, 32'h0010, 32'h0,        1'b1, 32'h0};
        vt[4]  = '{32'h0,        1'b1, 32'h0004, 32'hFFFFFFFF, 1'b0, 32'h0};
        vt[5]  = '{32'h0,        1'b0, 32'h0004, 32'h0,        1'b1, 32'h0000000F};
        vt[6]  = '{32'h0,        1'b1, 32'h0008, 32'hA5A50F0F, 1'b0, 32'h0};
        vt[7]  = '{32'h0,        1'b0, 32'h0008, 32'h0,        1'b1, 32'hA5A50F0F};
        vt[8]  = '{32'h0,        1'b1, 32'h000C, 32'hFFFFFFFF, 1'b0, 32'h0};
        vt[9]  = '{32'h0,        1'b0, 32'h000C, 32'h0,        1'b1, 32'h0};
        vt[10] = '{32'h0,        1'b1, 32'h0014, 32'hFFFFFFFF, 1'b0, 32'h0};
        vt[11] = '{32'h0,        1'b0, 32'h0014, 32'h0,        1'b1, 32'h0};
        vt[12] = '{32'h0,        1'b1, 32'h1004, 32'h3,        1'b0, 32'h0};
        vt[13] = '{32'h0,        1'b0, 32'h0004, 32'h0,        1'b1, 32'h3};
        vt[14] = '{32'h0,        1'b1, 32'h0008, 32'h0,        1'b0, 32'h0};
        vt[15] = '{32'h0,        1'b1, 32'h0004, 32'h0,        1'b0, 32'h0};
        vt[16] = '{32'h00001234, 1'b0, 32'h0008, 32'h0,        1'b1, 32'h0};
        vt[17] = '{32'h00001234, 1'b0, 32'h0010, 32'h0,        1'b1, 32'h00001234};
        vt[18] = '{32'h00001234, 1'b0, 32'h0000, 32'h0,        1'b1, 32'h00001234};
        vt[19] = '{32'h00001234, 1'b0, 32'h07FC, 32'h0,        1'b1, 32'h0};

        // Reset state
        rstn_i = 1'b0;
        irq_raw_i = '0; reg_en_i = 1'b0; reg_we_i = 1'b0;
        reg_addr_i = '0; reg_wdata_i = '0;
        #2;
        check("reset_irqs", irqs_o, 32'h0);
        check("reset_rdata", reg_rdata_o, 32'h0);
        check("ready", {31'h0, reg_ready_o}, 32'h1);
        do_reset();

        // Register vector table: strobe cycle then idle cycle
        for (int i = 0; i < 20; i++) begin
            irq_raw_i   = vt[i].raw;
            reg_en_i    = 1'b1;
            reg_we_i    = vt[i].we;
            reg_addr_i  = vt[i].addr;
            reg_wdata_i = vt[i].wdata;
            step(1);
            if (vt[i].chk) check($sformatf("vec%0d", i), reg_rdata_o, vt[i].exp);
            reg_en_i = 1'b0;
            reg_we_i = 1'b0;
            step(1);
        end

        // FILTER_LEN=0 level path: 3-cycle latency both ways on src3
        do_reset();
        irq_raw_i[3] = 1'b1;
        step(2); check("len0_rise_c2", irqs_o, 32'h0);
        step(1); check("len0_rise_c3", irqs_o, 32'h8);
        irq_raw_i[3] = 1'b0;
        step(2); check("len0_fall_c2", irqs_o, 32'h8);
        step(1); check("len0_fall_c3", irqs_o, 32'h0);

        // FILTER_LEN=4: 3-cycle pulse rejected, 8-cycle pulse high cycles 7..14
        do_reset();
        reg_write(32'h4, 32'h4);
        irq_raw_i[0] = 1'b1;
        step(3);
        irq_raw_i[0] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            seen |= irqs_o[0];
            step(1);
        end
        check("len4_short_reject", {31'h0, seen}, 32'h0);
        irq_raw_i[0] = 1'b1;
        got = '0;
        exp = '0;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            got[k-1] = irqs_o[0];
            exp[k-1] = (k >= 7 && k <= 14);
            if (k == 8) irq_raw_i[0] = 1'b0;
        end
        check("len4_long_window", {16'h0, got}, {16'h0, exp});

        // Latch mode: 1-cycle pulse held, LATCH_EN toggle keeps it, W1C clears
        do_reset();
        reg_write(32'h8, 32'h1);
        irq_raw_i[0] = 1'b1;
        step(1);
        irq_raw_i[0] = 1'b0;
        step(10); check("latch_held", irqs_o, 32'h1);
        reg_write(32'h8, 32'h0); check("latch_en_off_level", irqs_o, 32'h0);
        reg_write(32'h8, 32'h1); check("latch_survives_en_off", irqs_o, 32'h1);
        step(5);  check("latch_still_held", irqs_o, 32'h1);
        reg_write(32'hC, 32'h1); check("latch_clr", irqs_o, 32'h0);

        // Clear on the same cycle as a new rising edge on src5: set wins
        do_reset();
        reg_write(32'h8, 32'h20);
        irq_raw_i[5] = 1'b1;
        step(6); check("src5_latched", irqs_o, 32'h20);
        irq_raw_i[5] = 1'b0;
        step(6); check("src5_latch_after_fall", irqs_o, 32'h20);
        irq_raw_i[5] = 1'b1;
        step(3);
        reg_write(32'hC, 32'h20); check("src5_set_beats_clr", irqs_o, 32'h20);
        step(2); check("src5_set_beats_clr_hold", irqs_o, 32'h20);
        reg_write(32'hC, 32'h20); check("src5_plain_clr", irqs_o, 32'h0);

        // Shrinking FILTER_LEN mid-count flips on the following cycle
        do_reset();
        reg_write(32'h4, 32'hF);
        irq_raw_i[0] = 1'b1;
        step(12);
        reg_write(32'h4, 32'h2); check("shrink_no_flip_yet", irqs_o, 32'h0);
        step(1); check("shrink_flip", irqs_o, 32'h1);
        reg_read(32'h4, rd); check("shrink_read_len", rd, 32'h2);

        // Reset while latched and raw high; level mode returns after 3 cycles
        do_reset();
        reg_write(32'h8, 32'h80);
        irq_raw_i[7] = 1'b1;
        step(6); check("pre_reset_latched", irqs_o, 32'h80);
        #3 rstn_i = 1'b0;
        #1 check("async_reset_irqs", irqs_o, 32'h0);
        check("async_reset_rdata", reg_rdata_o, 32'h0);
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        step(2); check("post_reset_c2", irqs_o, 32'h0);
        step(1); check("post_reset_c3", irqs_o, 32'h80);
        reg_read(32'h8, rd); check("post_reset_latch_en", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
